// File: rtl/reconf_fir_filter_pkg.sv
// Shared constants, mode FSM type and multiply-accumulate helper for the 33-tap reconfigurable FIR.
package reconf_fir_filter_pkg;

  localparam int unsigned NTAP           = 33;
  localparam int unsigned IN_W           = 3;
  localparam int unsigned COEF_W         = 16;
  localparam int unsigned OUT_W          = 16;
  localparam int unsigned ACC_W          = 24;
  localparam int unsigned PROD_W         = IN_W + COEF_W;
  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned COEF_ADDR_BASE = 1;

  typedef enum logic {
    p_Idle   = 1'b0,
    p_Update = 1'b1
  } fir_state_e;

  // c*x as a full-precision 19-bit product, sign-extended and added to the incoming partial sum
  function automatic logic signed [ACC_W-1:0] fir_mac(
    input logic signed [COEF_W-1:0] c,
    input logic signed [IN_W-1:0]   x,
    input logic signed [ACC_W-1:0]  z
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(x);
    return ACC_W'(p) + z;
  endfunction

endpackage

// File: rtl/reconf_fir_filter_fir_tap.sv
// One transposed-form stage: z_o <= c*x + z_i, cleared while coefficients are being updated.
module fir_tap
  import reconf_fir_filter_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [IN_W-1:0]   x_i,
  input  logic signed [ACC_W-1:0]  z_i,
  output logic signed [ACC_W-1:0]  z_o
);

  logic signed [ACC_W-1:0] z_d;
  logic signed [ACC_W-1:0] z_q;

  assign z_d = fir_mac(coef_i, x_i, z_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      z_q <= '0;
    end else if (clr_i) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/reconf_fir_filter.sv
// 33-tap transposed-form FIR with SRAM-style coefficient download.
// Build option FIR_SATURATE_EN: saturate the output instead of wrapping to 16 bits.
module reconf_fir_filter
  import reconf_fir_filter_pkg::*;
(
  input  logic                     iClk_12M,
  input  logic                     iRsn,
  input  logic                     iCoeffiUpdateFlag,
  input  logic                     iCsnRam,
  input  logic                     iWrnRam,
  input  logic [ADDR_W-1:0]        iAddrRam,
  input  logic signed [COEF_W-1:0] iWrDtRam,
  input  logic signed [IN_W-1:0]   iFirIn,
  output logic signed [OUT_W-1:0]  oFirOut
);

  fir_state_e              state_q;
  logic signed [COEF_W-1:0] coef_q [NTAP];
  logic signed [COEF_W-1:0] coef_d [NTAP];
  logic                     wr_en_c;
  logic [ADDR_W-1:0]        wr_idx_c;
  logic                     clr_c;
  logic signed [ACC_W-1:0]  z [1:NTAP];
  logic signed [ACC_W-1:0]  sum0_c;
  logic signed [OUT_W-1:0]  out_d;
  logic signed [OUT_W-1:0]  out_q;

  // Writes are qualified by the flag itself, not by the registered mode
  assign wr_idx_c = iAddrRam - ADDR_W'(COEF_ADDR_BASE);
  assign wr_en_c  = iCoeffiUpdateFlag && !iCsnRam && !iWrnRam &&
                    (iAddrRam >= ADDR_W'(COEF_ADDR_BASE)) &&
                    (iAddrRam <  ADDR_W'(COEF_ADDR_BASE + NTAP));

  always_comb begin
    coef_d = coef_q;
    if (wr_en_c) begin
      coef_d[wr_idx_c] = iWrDtRam;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      coef_q <= coef_d;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= p_Idle;
    end else begin
      case (state_q)
        p_Idle:   if (iCoeffiUpdateFlag)  state_q <= p_Update;
        p_Update: if (!iCoeffiUpdateFlag) state_q <= p_Idle;
        default:  state_q <= p_Idle;
      endcase
    end
  end

  assign clr_c   = (state_q == p_Update);
  assign z[NTAP] = '0;

  // Taps 1..32; tap 0 is folded into the output stage below
  for (genvar k = 1; k < NTAP; k++) begin : g_tap
    fir_tap u_tap (
      .clk_i  (iClk_12M),
      .rst_ni (iRsn),
      .clr_i  (clr_c),
      .coef_i (coef_q[k]),
      .x_i    (iFirIn),
      .z_i    (z[k+1]),
      .z_o    (z[k])
    );
  end

  assign sum0_c = fir_mac(coef_q[0], iFirIn, z[1]);

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  always_comb begin
    out_d = OUT_W'(sum0_c);
    if (sum0_c > SatMax) begin
      out_d = OUT_W'(SatMax);
    end else if (sum0_c < SatMin) begin
      out_d = OUT_W'(SatMin);
    end
  end
`else
  assign out_d = OUT_W'(sum0_c);
`endif

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      out_q <= '0;
    end else if (clr_c) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign oFirOut = out_q;

endmodule

// File: tb/tb_reconf_fir_filter.sv
// Scoreboard bench for reconf_fir_filter: convolution model y[n] = sum c_k*x[n-k] since last clear.
module tb_reconf_fir_filter;

  localparam int NT = 33;

  logic        clk;
  logic        rst_n;
  logic        flag;
  logic        csn;
  logic        wrn;
  logic [5:0]  addr;
  logic [15:0] wd;
  logic [2:0]  fin;
  logic [15:0] fout;

  int vectors;
  int miscompares;
  int expq[$];

  int hist  [NT];
  int mcoef [NT];
  bit mupd;
  int sym   [NT];

  reconf_fir_filter dut (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iCoeffiUpdateFlag (flag),
    .iCsnRam           (csn),
    .iWrnRam           (wrn),
    .iAddrRam          (addr),
    .iWrDtRam          (wd),
    .iFirIn            (fin),
    .oFirOut           (fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int conv(input int y);
    logic [15:0] lo;
`ifdef FIR_SATURATE_EN
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return y;
`else
    lo = 16'(y);
    return int'($signed(lo));
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock's worth of inputs, predict the output after the coming edge, advance to the next negedge
  task automatic cyc(input bit f, input bit c, input bit w, input int a, input int d, input int x);
    int y;
    flag = f; csn = c; wrn = w; addr = 6'(a); wd = 16'(d); fin = 3'(x);
    if (!rst_n) begin
      for (int k = 0; k < NT; k++) begin hist[k] = 0; mcoef[k] = 0; end
      mupd = 1'b0;
      expq.push_back(0);
    end else begin
      if (!mupd) begin
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        y = 0;
        for (int k = 0; k < NT; k++) y += mcoef[k] * hist[k];
        expq.push_back(conv(y));
      end else begin
        for (int k = 0; k < NT; k++) hist[k] = 0;
        expq.push_back(0);
      end
      if (f && !c && !w && a >= 1 && a <= NT) mcoef[a-1] = d;
      mupd = f;
    end
    @(negedge clk);
  endtask

  task automatic cx(input int x);
    cyc(1'b0, 1'b1, 1'b1, 0, 0, x);
  endtask

  task automatic wr(input int a, input int d);
    cyc(1'b1, 1'b0, 1'b0, a, d, 0);
  endtask

  task automatic load_set(input int c [NT]);
    for (int k = 0; k < NT; k++) wr(k + 1, c[k]);
    cx(0);
  endtask

  task automatic impulse_chk(input string name);
    cx(1);
    chk({name, "_tap0"}, int'($signed(fout)), sym[0]);
    for (int k = 1; k < NT; k++) begin
      cx(0);
      chk($sformatf("%s_tap%0d", name, k), int'($signed(fout)), sym[k]);
    end
    cx(0);
    chk({name, "_tail"}, int'($signed(fout)), 0);
  endtask

  task automatic random_phase();
    for (int i = 0; i < 60; i++)
      cyc(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)) - 32768, 0);
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(0, 7)) - 4);
  endtask

  // Scoreboard monitor: one output per clock, sampled just after the edge
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("sb_out", int'($signed(fout)), e);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int zc [NT];
    int c17[NT];
    int cmx[NT];
    int base[17] = '{3, 0, -6, 7, 0, -11, 13, 0, -19, 24, 0, -37, 48, 0, -102, 206, 500};
    vectors = 0; miscompares = 0; mupd = 1'b0;
    for (int k = 0; k < NT; k++) begin
      hist[k] = 0; mcoef[k] = 0; zc[k] = 0; c17[k] = 0; cmx[k] = 32767;
    end
    c17[16] = 500;
    for (int k = 0; k < 17; k++) sym[k] = base[k];
    for (int k = 0; k < 16; k++) sym[17 + k] = base[15 - k];
    rst_n = 1'b0; flag = 1'b0; csn = 1'b1; wrn = 1'b1; addr = '0; wd = '0; fin = '0;

    cx(0); cx(0);
    chk("reset_out", int'($signed(fout)), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cx(int'($urandom_range(0, 7)) - 4);
    chk("zero_coef_out", int'($signed(fout)), 0);

    load_set(sym);
    impulse_chk("impulse");

    // Accesses that must not disturb the coefficient set
    cyc(1'b1, 1'b0, 1'b0, 0, 999, 0);
    cyc(1'b1, 1'b0, 1'b0, 40, 999, 0);
    cyc(1'b1, 1'b0, 1'b1, 17, 999, 0);
    cx(0);
    cyc(1'b0, 1'b0, 1'b0, 17, 1, 0);
    cx(0);
    impulse_chk("ignored");

    // Raise the flag in an impulse tail, then restart with a new tap 0
    cx(1);
    for (int i = 0; i < 5; i++) cx(0);
    wr(1, 10);
    wr(2, 0);
    chk("upd_clear", int'($signed(fout)), 0);
    cx(0);
    cx(1);
    chk("upd_new_tap0", int'($signed(fout)), 10);
    for (int i = 0; i < 34; i++) cx(0);

    load_set(zc);
    load_set(c17);
    cx(-4);
    for (int i = 0; i < 16; i++) cx(0);
    chk("neg_peak", int'($signed(fout)), -2000);
    for (int i = 0; i < 17; i++) cx(0);

    load_set(cmx);
    for (int i = 0; i < 40; i++) cx(3);
`ifdef FIR_SATURATE_EN
    chk("max_in", int'($signed(fout)), 32767);
`else
    chk("max_in", int'($signed(fout)), 32669);
`endif

    random_phase();

    // Asynchronous reset during an impulse tail wipes coefficients too
    load_set(sym);
    cx(1);
    for (int i = 0; i < 5; i++) cx(0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", int'($signed(fout)), 0);
    cx(0); cx(0);
    rst_n = 1'b1;
    cx(1);
    for (int i = 0; i < 20; i++) cx(0);
    chk("post_rst_coef", int'($signed(fout)), 0);

    cx(0);
    chk("sb_drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
